// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle fetch/execute control-flow sequencer owning the architectural PC
module pc_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [63:0] TRAP_PC  = 64'h0000_0000_8000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [63:0] pc,
   output logic [63:0] link_pc,
   input  logic        exe_done,
   input  logic        jal_en,
   input  logic [63:0] jal_target,
   input  logic        jalr_en,
   input  logic [63:0] jalr_target,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   input  logic        halt,
   output logic        misalign,
   output logic        halted,
   output logic [63:0] retire_cnt
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        misalign_q, misalign_d;
   logic [63:0] retire_q, retire_d;
   logic [63:0] seq_pc;
   logic [63:0] next_pc;

   // Sequential successor; wraps naturally at 2^64
   assign seq_pc = pc_q + 64'd4;

   // Next-PC selection by fixed priority: jalr > jal > branch > sequential
   always_comb begin
      next_pc = seq_pc;
      if (jalr_en) begin
         next_pc = jalr_target;
      end else if (jal_en) begin
         next_pc = jal_target;
      end else if (br_taken) begin
         next_pc = br_target;
      end
   end

   // State register; reset aborts any outstanding fetch immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         inst_q     <= 32'd0;
         misalign_q <= 1'b0;
         retire_q   <= 64'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         misalign_q <= misalign_d;
         retire_q   <= retire_d;
      end
   end

   // Next-state logic: fetch handshake, execute completion, redirect/trap/halt
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      misalign_d = misalign_q;
      retire_d   = retire_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready) begin
               inst_d  = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exe_done) begin
               if (halt) begin
                  // Halting instruction retires but the PC stays on it
                  retire_d = retire_q + 64'd1;
                  state_d  = S_HALT;
               end else if (next_pc[1:0] != 2'b00) begin
                  // Faulting instruction is not counted as retired
                  misalign_d = 1'b1;
                  pc_d       = TRAP_PC;
                  state_d    = S_FETCH;
               end else begin
                  pc_d     = next_pc;
                  retire_d = retire_q + 64'd1;
                  state_d  = S_FETCH;
               end
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_valid = (state_q == S_EXEC);
   assign pc         = pc_q;
   assign link_pc    = seq_pc;
   assign misalign   = misalign_q;
   assign halted     = (state_q == S_HALT);
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with an in-bench reference model
module tb_pc_sequencer;

   localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] TRP_PC  = 64'h0000_0000_8000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] inst;
   logic        inst_valid;
   logic [63:0] pc;
   logic [63:0] link_pc;
   logic        exe_done = 1'b0;
   logic        jal_en = 1'b0;
   logic [63:0] jal_target = 64'd0;
   logic        jalr_en = 1'b0;
   logic [63:0] jalr_target = 64'd0;
   logic        br_taken = 1'b0;
   logic [63:0] br_target = 64'd0;
   logic        halt = 1'b0;
   logic        misalign;
   logic        halted;
   logic [63:0] retire_cnt;

   int total = 0;
   int bad   = 0;

   pc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .inst_valid  (inst_valid),
      .pc          (pc),
      .link_pc     (link_pc),
      .exe_done    (exe_done),
      .jal_en      (jal_en),
      .jal_target  (jal_target),
      .jalr_en     (jalr_en),
      .jalr_target (jalr_target),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .halt        (halt),
      .misalign    (misalign),
      .halted      (halted),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: phase 0=idle after reset, 1=fetching, 2=executing, 3=halted
   int          m_phase;
   logic [63:0] m_pc;
   logic [31:0] m_inst;
   logic [63:0] m_ret;
   logic        m_mis;

   always @(posedge clk or negedge rst_n) begin
      logic [63:0] tgt;
      if (!rst_n) begin
         m_phase = 0; m_pc = RST_PC; m_inst = 32'd0; m_ret = 64'd0; m_mis = 1'b0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (imem_ready) begin
            m_inst  = imem_rdata;
            m_phase = 2;
         end
      end else if (m_phase == 2 && exe_done) begin
         if (halt) begin
            m_ret   = m_ret + 1;
            m_phase = 3;
         end else begin
            if (jalr_en)       tgt = jalr_target;
            else if (jal_en)   tgt = jal_target;
            else if (br_taken) tgt = br_target;
            else               tgt = m_pc + 64'd4;
            if (tgt % 4 != 0) begin
               m_mis = 1'b1;
               m_pc  = TRP_PC;
            end else begin
               m_pc  = tgt;
               m_ret = m_ret + 1;
            end
            m_phase = 1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("imem_req",   {63'd0, imem_req},   {63'd0, m_phase == 1});
         chk("imem_addr",  imem_addr,           m_pc);
         chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_phase == 2});
         chk("halted",     {63'd0, halted},     {63'd0, m_phase == 3});
         chk("pc",         pc,                  m_pc);
         chk("link_pc",    link_pc,             m_pc + 64'd4);
         chk("inst",       {32'd0, inst},       {32'd0, m_inst});
         chk("misalign",   {63'd0, misalign},   {63'd0, m_mis});
         chk("retire_cnt", retire_cnt,          m_ret);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_one(input logic [31:0] word);
      imem_ready = 1'b1; imem_rdata = word;
      step();
      imem_ready = 1'b0;
   endtask

   task automatic exec_one(input logic jr, input logic [63:0] jrt, input logic j, input logic [63:0] jt,
                           input logic b, input logic [63:0] bt, input logic h);
      exe_done = 1'b1; jalr_en = jr; jalr_target = jrt; jal_en = j; jal_target = jt;
      br_taken = b; br_target = bt; halt = h;
      step();
      exe_done = 1'b0; jalr_en = 1'b0; jal_en = 1'b0; br_taken = 1'b0; halt = 1'b0;
   endtask

   logic [63:0] addrs[$];
   localparam logic [63:0] X = 64'd0;

   initial begin
      // Reset state
      #12;
      chk("rst imem_req", {63'd0, imem_req}, 64'd0);
      chk("rst pc", pc, 64'h8000_0000);
      chk("rst retire", retire_cnt, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back sequential execution, ready and done tied high
      imem_ready = 1'b1; exe_done = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (imem_req) addrs.push_back(imem_addr);
         @(posedge clk);
      end
      #1;
      chk("seq count", addrs.size(), 3);
      chk("seq addr0", (addrs.size() > 0) ? addrs[0] : X, 64'h8000_0000);
      chk("seq addr1", (addrs.size() > 1) ? addrs[1] : X, 64'h8000_0004);
      chk("seq addr2", (addrs.size() > 2) ? addrs[2] : X, 64'h8000_0008);
      chk("seq retire", retire_cnt, 64'd3);

      // Fetch stalled for 5 cycles
      imem_ready = 1'b0; exe_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall req", {63'd0, imem_req}, 64'd1);
         chk("stall addr", imem_addr, 64'h8000_000C);
      end
      fetch_one(32'h0000_0013);
      chk("latched inst", {32'd0, inst}, 64'h13);
      chk("exec valid", {63'd0, inst_valid}, 64'd1);
      exec_one(0, X, 0, X, 0, X, 0);
      chk("seq to 10", imem_addr, 64'h8000_0010);

      // Priority: jal over branch, then jalr over both
      fetch_one(32'h0400_006F);
      chk("link_pc", link_pc, 64'h8000_0014);
      exec_one(0, X, 1, 64'h8000_0040, 1, 64'h8000_0020, 0);
      chk("jal wins", imem_addr, 64'h8000_0040);
      chk("jal retire", retire_cnt, 64'd5);
      fetch_one(32'h0000_8067);
      exec_one(1, 64'h8000_0080, 1, 64'h8000_0040, 1, 64'h8000_0020, 0);
      chk("jalr wins", imem_addr, 64'h8000_0080);

      // Misaligned branch traps; faulting instruction not counted
      fetch_one(32'h0000_0063);
      exec_one(0, X, 0, X, 1, 64'h8000_0022, 0);
      chk("trap addr", imem_addr, 64'h8000_0100);
      chk("trap flag", {63'd0, misalign}, 64'd1);
      chk("trap retire", retire_cnt, 64'd6);
      fetch_one(32'h0000_0013);
      exec_one(0, X, 0, X, 0, X, 0);
      chk("sticky flag", {63'd0, misalign}, 64'd1);
      chk("after trap", imem_addr, 64'h8000_0104);

      // Halt ignores redirect and is terminal
      fetch_one(32'h0010_0073);
      exec_one(0, X, 1, 64'h8000_0040, 0, X, 1);
      chk("halted", {63'd0, halted}, 64'd1);
      chk("halt retire", retire_cnt, 64'd8);
      chk("halt pc", pc, 64'h8000_0104);
      for (int i = 0; i < 20; i++) begin
         imem_ready = i[0]; exe_done = ~i[0];
         step();
         chk("halt no req", {63'd0, imem_req}, 64'd0);
      end
      imem_ready = 1'b0; exe_done = 1'b0;

      // Asynchronous reset in the middle of a fetch
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      fetch_one(32'h0000_0063);
      exec_one(0, X, 0, X, 1, 64'h8000_0002, 0);
      fetch_one(32'h0000_0013);
      exec_one(0, X, 0, X, 0, X, 0);
      chk("pre-rst req", {63'd0, imem_req}, 64'd1);
      chk("pre-rst addr", imem_addr, 64'h8000_0104);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async req", {63'd0, imem_req}, 64'd0);
      chk("async pc", pc, 64'h8000_0000);
      chk("async retire", retire_cnt, 64'd0);
      chk("async misalign", {63'd0, misalign}, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle control-flow sequencer for the RV64 core. Owns the architectural PC.
- Fetches each instruction over a request/ready handshake to instruction memory, presents it to decode/execute, and waits for execute completion.
- Selects the next PC from the JAL, JALR and branch units or the sequential path, and traps misaligned targets.
- Sits between instruction memory and the decode/jump/branch logic; it is the only writer of PC.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- TRAP_PC, 64'h0000_0000_8000_0100, PC loaded on misaligned-target trap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  64  fetch address (= pc); stable while imem_req=1.
- imem_ready  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  latched instruction for decode.
- inst_valid  out  1  high throughout EXEC state.
- pc  out  64  address of the current instruction.
- link_pc  out  64  pc+4 (mod 2^64); the pc value supplied to the jump/branch units and the JAL/JALR link value.
- exe_done  in  1  execute finished; redirect inputs are valid this cycle.
- jal_en  in  1  JAL redirect request.
- jal_target  in  64  JAL target.
- jalr_en  in  1  JALR redirect request.
- jalr_target  in  64  JALR target (bit0 already cleared).
- br_taken  in  1  conditional branch taken.
- br_target  in  64  branch target.
- halt  in  1  instruction is a halt (ebreak); sampled with exe_done.
- misalign  out  1  sticky flag: misaligned control-flow target trapped.
- halted  out  1  sequencer is in HALT.
- retire_cnt  out  64  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, pc=RESET_PC, inst=0.
  - imem_req=0, inst_valid=0, misalign=0, halted=0, retire_cnt=0.
  - Reset may occur in any state and aborts any outstanding fetch; imem_req drops immediately.
- BOOT:
  - All outputs idle for one cycle, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: inst<=imem_rdata, go to EXEC.
  - Without imem_ready: stay in FETCH, holding request and address stable.
- EXEC:
  - inst_valid=1; inst, pc and link_pc are stable.
  - Without exe_done: stay in EXEC.
  - On exe_done, select the next PC by fixed priority: jalr_en > jal_en > br_taken > link_pc. Lower-priority simultaneous requests are ignored.
  - halt=1 with exe_done: retire_cnt+1, pc unchanged, go to HALT. Redirects are ignored.
  - Selected target with bits[1:0]!=0:
    - misalign<=1 (sticky until reset), pc<=TRAP_PC, go to FETCH.
    - The faulting instruction is not counted.
    - Only the redirect path can misalign; link_pc inherits pc alignment.
  - Otherwise: pc<=selected target, retire_cnt+1 (wraps at 2^64), go to FETCH.
- HALT:
  - halted=1, imem_req=0, inst_valid=0.
  - Terminal state; only reset leaves it.
- Timing and arithmetic:
  - Minimum 2 cycles per instruction: imem_ready in the first FETCH cycle, then exe_done in the first EXEC cycle.
  - All state updates occur on the clk edge at which the handshake is sampled.
  - pc+4 and all target arithmetic are modulo 2^64; link_pc of pc=64'hFFFF_FFFF_FFFF_FFFC is 0.
  - Inputs other than imem_ready/imem_rdata are ignored outside EXEC. imem_ready is ignored outside FETCH.

Test Plan:
- Reset release, imem_ready tied 1, exe_done tied 1, no redirects -> imem_addr sequence 8000_0000, 8000_0004, 8000_0008 on alternate cycles; retire_cnt=3 after 6 cycles post-BOOT.
- imem_ready withheld 5 cycles in FETCH -> imem_req and imem_addr held constant throughout; inst latches imem_rdata=32'h0000_0013 on the ready cycle.
- In EXEC at pc=8000_0010: jal_en=1 with target 8000_0040, plus br_taken=1 with target 8000_0020 -> next fetch at 8000_0040. Repeat with jalr_en=1 target 8000_0080 -> 8000_0080.
- br_taken=1, br_target=8000_0022 -> misalign=1, next fetch at 8000_0100, retire_cnt unchanged. misalign stays 1 after later normal instructions.
- halt=1 with exe_done -> halted=1, retire_cnt+1, imem_req stays 0 for 20 cycles despite imem_ready/exe_done toggling.
- rst_n asserted mid-FETCH with imem_req=1 -> imem_req=0 and pc=8000_0000 asynchronously, before the next clk edge. Counter and flags are cleared.
